loop_uhat_sparse_row_acc: RTL and testbench
===========================================

Name: loop_uhat_sparse_row_acc

Overview:
- Downstream consumer of the 49x44 unsigned sparse-product multiplier (4-cycle register pipeline, clock-enabled).
- Issues the multiplier's `ce`. Tracks valid/last flags alongside the multiplier pipeline. Accumulates the 93-bit products of one sparse row.
- At row end, rounds and shifts the sum back to fixed-point, saturates it, and presents the row result on a valid/ready output.
- Backpressure from the output stalls both the multiplier and the upstream feeder.

Parameters:
- PROD_W, 93, product width from the multiplier.
- MUL_LAT, 4, multiplier latency in enabled cycles (input regs + 3 product regs).
- ACC_W, 109, accumulator width (PROD_W + 16 bits headroom).
- FRAC, 44, fraction bits dropped at output; FRAC >= 1.
- OUT_W, 49, result width.
- CNT_W, 16, term-counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair presented to the multiplier this cycle.
- in_last  in  1  qualifies in_valid: final term of the current row.
- in_ready  out  1  upstream may advance; equals mul_ce.
- mul_ce  out  1  clock enable driven to the multiplier's ce.
- prod  in  PROD_W  multiplier dout (unsigned).
- out_valid  out  1  row result held.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  rounded, saturated row sum.
- out_sat  out  1  result saturated.
- out_terms  out  CNT_W  number of terms in the row (saturating).

Behaviour:
- Reset (async, active-high) clears the following to 0:
  - valid/last delay line
  - acc, term_cnt
  - out_valid, out_data, out_sat, out_terms
- Reset mid-row discards the partial row; no result is emitted for it.
- stall = out_valid & ~out_ready. mul_ce = in_ready = ~stall. While stall is high all pipeline state holds, in lockstep with the multiplier's ce.
- Input accept = in_valid & mul_ce. The delay line has MUL_LAT stages of {v, l}, advancing only when mul_ce is high. Stage 0 loads {in_valid & mul_ce, in_last}.
- Tail stage {tv, tl} aligns with prod. When tv & mul_ce:
  - sum = acc + zero-extend(prod) (ACC_W bits, no wrap for < 2^16 terms).
  - tl = 0: acc <= sum; term_cnt <= term_cnt + 1, saturating at 2^CNT_W - 1.
  - tl = 1:
    - acc <= 0, term_cnt <= 0.
    - r = (sum + 2^(FRAC-1)) >> FRAC (round half up).
    - out_data <= min(r, 2^OUT_W - 1).
    - out_sat <= (r > 2^OUT_W - 1).
    - out_terms <= sat(term_cnt + 1).
    - out_valid <= 1.
- out_valid clears on out_valid & out_ready unless a new tl result loads in the same cycle, in which case the new result is loaded.
- Output data/flags are stable while out_valid & ~out_ready.
- Latency: a last term accepted at cycle t with mul_ce continuously high gives out_valid at t + MUL_LAT + 1.
- Throughput: one term per cycle. A row ending while the previous result is unaccepted stalls until it is taken.
- in_last without in_valid is ignored. A single-term row (valid & last) is legal.
- Rows of length >= 2^16 are not supported; out_terms pins at max.

Decomposition:
- Package loop_uhat_sparse_pkg holds:
  - PROD_W, ACC_W, FRAC, OUT_W, CNT_W constants
  - the {v, l} tag struct
  - the round/saturate function
- Sub-module loop_uhat_sparse_tag_pipe: MUL_LAT-deep enable-gated {v, l} shift register with async reset.

Test Plan:
- Row of prods 2^44, 2^44, 2^43 (last on 3rd), out_ready = 1 -> one result: out_data = 3, out_sat = 0, out_terms = 3, out_valid exactly at accept-of-last + 5.
- Single term prod = 2^43 - 1, valid & last -> out_data = 0. Then prod = 2^43 -> out_data = 1 (half-up boundary).
- Two terms of 2^92 -> r = 2^49 > 2^49 - 1 -> out_data = 2^49 - 1, out_sat = 1.
- out_ready held 0 for 6 cycles after a result while a 2nd row streams -> mul_ce/in_ready drop the cycle out_valid rises. 2nd row's partial acc and tags frozen. After release, 2nd result is correct with no lost or duplicated term.
- Back-to-back rows with out_ready = 1 and bubbles (in_valid = 0 every other cycle) -> each result equals its own row sum; acc starts from 0 per row.
- Assert reset for 1 cycle mid-row (after 2 of 4 terms) -> no output. Next row of one term 5*2^44 -> out_data = 5, out_terms = 1.

Source files
------------

// File: rtl/loop_uhat_sparse_pkg.sv
// rtl/loop_uhat_sparse_pkg.sv - shared constants, tag/result types and the round/saturate helper
package loop_uhat_sparse_pkg;

  localparam int PROD_W  = 93;
  localparam int MUL_LAT = 4;
  localparam int ACC_W   = 109;
  localparam int FRAC    = 44;
  localparam int OUT_W   = 49;
  localparam int CNT_W   = 16;
  localparam int R_W     = ACC_W + 1 - FRAC;

  typedef struct packed {
    logic v;
    logic l;
  } tag_t;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } rnd_t;

  // Round half up at the FRAC boundary; one extra bit keeps the bias add from wrapping.
  function automatic rnd_t round_sat(input logic [ACC_W-1:0] sum);
    logic [ACC_W:0] biased;
    logic [R_W-1:0] r;
    rnd_t           res;
    biased   = {1'b0, sum} + ({{ACC_W{1'b0}}, 1'b1} << (FRAC - 1));
    r        = R_W'(biased >> FRAC);
    res.sat  = (r > R_W'({OUT_W{1'b1}}));
    res.data = res.sat ? {OUT_W{1'b1}} : r[OUT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/loop_uhat_sparse_tag_pipe.sv
// rtl/loop_uhat_sparse_tag_pipe.sv - enable-gated {v, l} delay line kept in step with the multiplier
module loop_uhat_sparse_tag_pipe
  import loop_uhat_sparse_pkg::*;
#(
  parameter int DEPTH = MUL_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  tag_t i_tag,
  output tag_t o_tail
);

  tag_t [DEPTH-1:0] r_stage;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= '0;
    end else if (i_en) begin
      r_stage <= {r_stage[DEPTH-2:0], i_tag};
    end
  end

  assign o_tail = r_stage[DEPTH-1];

endmodule

// File: rtl/loop_uhat_sparse_row_acc.sv
// rtl/loop_uhat_sparse_row_acc.sv - per-row accumulator behind the sparse-product multiplier
module loop_uhat_sparse_row_acc
  import loop_uhat_sparse_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mul_ce,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_terms
);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_term_cnt;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_sat;
  logic [CNT_W-1:0] r_out_terms;

  logic             w_ce;
  tag_t             w_tag_in;
  tag_t             w_tail;
  logic             w_fire;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_inc;
  rnd_t             w_rnd;

  // The whole pipeline, including the external multiplier, freezes while a result waits.
  assign w_ce     = ~(r_out_valid & ~out_ready);
  assign mul_ce   = w_ce;
  assign in_ready = w_ce;

  assign w_tag_in.v = in_valid & w_ce;
  assign w_tag_in.l = in_last;

  loop_uhat_sparse_tag_pipe #(.DEPTH(MUL_LAT)) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_ce),
    .i_tag  (w_tag_in),
    .o_tail (w_tail)
  );

  assign w_fire    = w_tail.v & w_ce;
  assign w_sum     = r_acc + ACC_W'(prod);
  assign w_cnt_inc = (r_term_cnt == {CNT_W{1'b1}}) ? r_term_cnt : r_term_cnt + 1'b1;
  assign w_rnd     = round_sat(w_sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_term_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_terms <= '0;
    end else if (w_fire && !w_tail.l) begin
      r_acc      <= w_sum;
      r_term_cnt <= w_cnt_inc;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
    end else if (w_fire && w_tail.l) begin
      r_acc       <= '0;
      r_term_cnt  <= '0;
      r_out_valid <= 1'b1;
      r_out_data  <= w_rnd.data;
      r_out_sat   <= w_rnd.sat;
      r_out_terms <= w_cnt_inc;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_terms = r_out_terms;

endmodule

// File: tb/tb_loop_uhat_sparse_row_acc.sv
// tb/tb_loop_uhat_sparse_row_acc.sv - scoreboard bench with a behavioural 4-stage multiplier
module tb_loop_uhat_sparse_row_acc;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         mul_ce;
  logic [92:0]  prod;
  logic         out_valid;
  logic         out_ready;
  logic [48:0]  out_data;
  logic         out_sat;
  logic [15:0]  out_terms;

  logic [92:0]  op;
  logic [92:0]  mul_pipe [4];

  typedef struct {
    logic [48:0] d;
    logic        s;
    logic [15:0] t;
  } exp_t;

  exp_t          sb[$];
  logic [127:0]  exp_sum;
  logic [15:0]   exp_cnt;
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  loop_uhat_sparse_row_acc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mul_ce    (mul_ce),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_terms (out_terms)
  );

  // Stand-in for the multiplier: operand is the product, delayed 4 enabled edges.
  always @(posedge clk) begin
    if (mul_ce) begin
      mul_pipe[0] <= op;
      for (int i = 1; i < 4; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end
  assign prod = mul_pipe[3];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_sat", out_sat, e.s);
        check("out_terms", out_terms, e.t);
      end
    end
  end

  task automatic push_expected();
    logic [127:0] r;
    exp_t e;
    r = (exp_sum + (128'd1 << 43)) >> 44;
    e.s = (r > ((128'd1 << 49) - 1));
    e.d = e.s ? {49{1'b1}} : r[48:0];
    e.t = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic send(input logic v, input logic l, input logic [92:0] val);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    in_valid = v;
    in_last = l;
    op = val;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        check("send_timeout", 0, 1);
        done = 1'b1;
        v = 1'b0;
      end
    end
    if (v) begin
      exp_sum = exp_sum + 128'(val);
      if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 1'b1;
      if (l) begin
        push_expected();
        exp_sum = '0;
        exp_cnt = '0;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    op = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", (sb.size() == 0 && !out_valid), 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_sat"}, out_sat, 0);
    check({tag, "_out_terms"}, out_terms, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int            n;
    logic [48:0]   held;
    logic [92:0]   v;
    int            row_len [3];

    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    op = '0;
    exp_sum = '0;
    exp_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic row with latency measurement.
    send(1, 0, 93'd1 << 44);
    send(1, 0, 93'd1 << 44);
    send(1, 1, 93'd1 << 43);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 5);
    drain();

    // Half-up rounding boundary.
    send(1, 1, (93'd1 << 43) - 1);
    send(1, 1, 93'd1 << 43);
    drain();

    // Saturation.
    send(1, 0, 93'd1 << 92);
    send(1, 1, 93'd1 << 92);
    drain();

    // Backpressure while the next row streams in.
    out_ready = 1'b0;
    fork
      begin
        send(1, 1, 93'd7 << 44);
        for (int i = 0; i < 5; i++) send(1, (i == 4), (93'(i + 1) << 44) + 93'(i));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("stall_seen", out_valid, 1);
        check("stall_mul_ce", mul_ce, 0);
        check("stall_in_ready", in_ready, 0);
        held = out_data;
        repeat (6) @(negedge clk);
        check("stall_hold_data", out_data, held);
        check("stall_hold_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Back-to-back rows with bubbles.
    row_len[0] = 3;
    row_len[1] = 2;
    row_len[2] = 4;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < row_len[r]; k++) begin
        v = 93'({$urandom, $urandom, $urandom});
        if (r == 1) v = v >> 30;
        send(1, (k == row_len[r] - 1), v);
        send(0, 0, '0);
      end
    end
    drain();

    // Reset mid-row discards the partial row.
    send(1, 0, 93'd9 << 44);
    send(1, 0, 93'd9 << 44);
    reset = 1'b1;
    exp_sum = '0;
    exp_cnt = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("midrow_reset");
    repeat (10) @(posedge clk);
    #1;
    check("no_output_after_reset", out_valid, 0);
    send(1, 1, 93'd5 << 44);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
